// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline register for MiniRiscV: falling-edge capture, in-block forwarding
// resolution, valid/bubble tracking, stall with operand refresh, saturating bubble count.
module id_ex_stage_buf #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         rs1_data_o,
  output logic [XLEN-1:0]         rs2_data_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [4:0]              rd_o,
  output logic [2:0]              func3_o,
  output logic [6:0]              func7_o,
  output logic [1:0]              fwd_hit_o,
  output logic [CNT_W-1:0]        bubble_cnt_o
);

  logic [4:0]      r1_sel, r2_sel;
  logic            m1_hit, m2_hit;
  logic [XLEN-1:0] m1_data, m2_data;
  logic            cnt_sat;

  // While stalled, refresh looks up the held register numbers; otherwise the incoming ones.
  assign r1_sel  = stall ? rs1_o : instr_i[19:15];
  assign r2_sel  = stall ? rs2_o : instr_i[24:20];
  assign cnt_sat = &bubble_cnt_o;

  // Lowest-index matching source wins; x0 never matches.
  always_comb begin
    m1_hit  = 1'b0;
    m2_hit  = 1'b0;
    m1_data = '0;
    m2_data = '0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!m1_hit && fwd_we[k] && (r1_sel != 5'd0) && (fwd_rd[5*k +: 5] == r1_sel)) begin
        m1_hit  = 1'b1;
        m1_data = fwd_data[XLEN*k +: XLEN];
      end
      if (!m2_hit && fwd_we[k] && (r2_sel != 5'd0) && (fwd_rd[5*k +: 5] == r2_sel)) begin
        m2_hit  = 1'b1;
        m2_data = fwd_data[XLEN*k +: XLEN];
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid_o      <= 1'b0;
      ctrl_o       <= '0;
      imm_o        <= '0;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
      rs1_o        <= '0;
      rs2_o        <= '0;
      rd_o         <= '0;
      func3_o      <= '0;
      func7_o      <= '0;
      fwd_hit_o    <= '0;
      bubble_cnt_o <= '0;
    end else if (clear) begin
      valid_o    <= 1'b0;
      ctrl_o     <= '0;
      imm_o      <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      func3_o    <= '0;
      func7_o    <= '0;
      fwd_hit_o  <= '0;
      if (!cnt_sat) bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end else if (stall) begin
      if (valid_o && m1_hit) begin
        rs1_data_o   <= m1_data;
        fwd_hit_o[0] <= 1'b1;
      end
      if (valid_o && m2_hit) begin
        rs2_data_o   <= m2_data;
        fwd_hit_o[1] <= 1'b1;
      end
    end else begin
      valid_o    <= in_valid;
      ctrl_o     <= in_valid ? ctrl_i : '0;
      imm_o      <= imm_i;
      rs1_data_o <= m1_hit ? m1_data : rs1_data_i;
      rs2_data_o <= m2_hit ? m2_data : rs2_data_i;
      rs1_o      <= instr_i[19:15];
      rs2_o      <= instr_i[24:20];
      rd_o       <= instr_i[11:7];
      func3_o    <= instr_i[14:12];
      func7_o    <= instr_i[31:25];
      fwd_hit_o  <= {m2_hit, m1_hit};
      if (!in_valid && !cnt_sat) bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Self-checking bench for id_ex_stage_buf: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_id_ex_stage_buf;

  logic        clk = 1'b1;
  logic        rst;
  logic        clear, stall, in_valid;
  logic [7:0]  ctrl_i;
  logic [31:0] instr_i, imm_i, rs1_data_i, rs2_data_i;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;

  logic        valid_o;
  logic [7:0]  ctrl_o;
  logic [31:0] imm_o, rs1_data_o, rs2_data_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  func3_o;
  logic [6:0]  func7_o;
  logic [1:0]  fwd_hit_o;
  logic [15:0] bubble_cnt_o;

  logic        s_valid;
  logic [7:0]  s_ctrl;
  logic [31:0] s_imm, s_rs1d, s_rs2d;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_f3;
  logic [6:0]  s_f7;
  logic [1:0]  s_hit;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_imm, m_rs1d, m_rs2d;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [1:0]  m_hit;
  int          m_cnt, m_cnt4;

  always #5 clk = ~clk;

  id_ex_stage_buf #(.XLEN(32), .CTRL_W(8), .NUM_FWD(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .stall(stall), .in_valid(in_valid),
    .ctrl_i(ctrl_i), .instr_i(instr_i), .imm_i(imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .imm_o(imm_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .func3_o(func3_o), .func7_o(func7_o),
    .fwd_hit_o(fwd_hit_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage_buf #(.XLEN(32), .CTRL_W(8), .NUM_FWD(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .stall(stall), .in_valid(in_valid),
    .ctrl_i(ctrl_i), .instr_i(instr_i), .imm_i(imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .valid_o(s_valid), .ctrl_o(s_ctrl), .imm_o(s_imm),
    .rs1_data_o(s_rs1d), .rs2_data_o(s_rs2d),
    .rs1_o(s_rs1), .rs2_o(s_rs2), .rd_o(s_rd),
    .func3_o(s_f3), .func7_o(s_f7),
    .fwd_hit_o(s_hit), .bubble_cnt_o(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(valid_o), 64'(m_valid));
    check({tag, ".ctrl"},  64'(ctrl_o), 64'(m_ctrl));
    check({tag, ".imm"},   64'(imm_o), 64'(m_imm));
    check({tag, ".rs1d"},  64'(rs1_data_o), 64'(m_rs1d));
    check({tag, ".rs2d"},  64'(rs2_data_o), 64'(m_rs2d));
    check({tag, ".rs1"},   64'(rs1_o), 64'(m_rs1));
    check({tag, ".rs2"},   64'(rs2_o), 64'(m_rs2));
    check({tag, ".rd"},    64'(rd_o), 64'(m_rd));
    check({tag, ".f3"},    64'(func3_o), 64'(m_f3));
    check({tag, ".f7"},    64'(func7_o), 64'(m_f7));
    check({tag, ".hit"},   64'(fwd_hit_o), 64'(m_hit));
    check({tag, ".cnt"},   64'(bubble_cnt_o), 64'(m_cnt));
    check({tag, ".cnt4"},  64'(s_cnt), 64'(m_cnt4));
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_hit = 0;
    m_cnt = 0; m_cnt4 = 0;
  endtask

  // first forwarding source (scanning from index 0) that writes register r, x0 excluded
  task automatic lookup(input logic [4:0] r, output logic hit, output logic [31:0] data);
    hit = 0; data = 0;
    for (int k = 0; k < 2; k++)
      if (!hit && r != 0 && fwd_we[k] && fwd_rd[5*k +: 5] == r) begin
        hit = 1; data = fwd_data[32*k +: 32];
      end
  endtask

  task automatic count_bubble();
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt4 < 15) m_cnt4++;
  endtask

  task automatic model_edge();
    logic h1, h2;
    logic [31:0] d1, d2;
    if (clear) begin
      m_valid = 0; m_ctrl = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_hit = 0;
      count_bubble();
    end else if (stall) begin
      if (m_valid) begin
        lookup(m_rs1, h1, d1);
        lookup(m_rs2, h2, d2);
        if (h1) begin m_rs1d = d1; m_hit[0] = 1; end
        if (h2) begin m_rs2d = d2; m_hit[1] = 1; end
      end
    end else begin
      lookup(instr_i[19:15], h1, d1);
      lookup(instr_i[24:20], h2, d2);
      m_valid = in_valid;
      m_ctrl  = in_valid ? ctrl_i : 8'h0;
      if (!in_valid) count_bubble();
      m_imm  = imm_i;
      m_rs1  = instr_i[19:15];
      m_rs2  = instr_i[24:20];
      m_rd   = instr_i[11:7];
      m_f3   = instr_i[14:12];
      m_f7   = instr_i[31:25];
      m_rs1d = h1 ? d1 : rs1_data_i;
      m_rs2d = h2 ? d2 : rs2_data_i;
      m_hit  = {h2, h1};
    end
  endtask

  // inputs stay stable across the falling edge; outputs sampled 1 time unit after it
  task automatic tick(input string tag);
    @(negedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] rd, input logic [31:0] d);
    fwd_we[k] = we;
    fwd_rd[5*k +: 5] = rd;
    fwd_data[32*k +: 32] = d;
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [4:0] r2,
                                           input logic [4:0] r1, input logic [2:0] f3,
                                           input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction

  task automatic idle_inputs();
    clear = 0; stall = 0; in_valid = 1; ctrl_i = 8'h5A;
    instr_i = 0; imm_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    fwd_we = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    rst = 1;

    // load with forwarding on both operands
    instr_i = mk_instr(7'h20, 5'd6, 5'd5, 3'd5, 5'd10);
    imm_i = 32'hFFFF_FFF0; rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'h1;
    set_fwd(0, 1, 5'd5, 32'hAAAA_0000);
    set_fwd(1, 1, 5'd6, 32'h1234_5678);
    tick("fwd_load");
    check("fwd_load.rs1d_const", 64'(rs1_data_o), 64'hAAAA_0000);
    check("fwd_load.rs2d_const", 64'(rs2_data_o), 64'h1234_5678);
    check("fwd_load.hit_const", 64'(fwd_hit_o), 64'h3);

    // both sources target the same register: index 0 wins
    instr_i = mk_instr(7'h0, 5'd1, 5'd7, 3'd0, 5'd3);
    set_fwd(0, 1, 5'd7, 32'h11);
    set_fwd(1, 1, 5'd7, 32'h22);
    tick("prio");
    check("prio.rs1d_const", 64'(rs1_data_o), 64'h11);

    // x0 never forwarded
    instr_i = mk_instr(7'h0, 5'd2, 5'd0, 3'd1, 5'd4);
    rs1_data_i = 0;
    set_fwd(0, 1, 5'd0, 32'hBAD0);
    set_fwd(1, 0, 5'd0, 32'h0);
    tick("x0");
    check("x0.rs1d_const", 64'(rs1_data_o), 64'h0);
    check("x0.hit0_const", 64'(fwd_hit_o[0]), 64'h0);

    // stall refresh on rs2
    idle_inputs();
    ctrl_i = 8'hC3; imm_i = 32'h0000_0444;
    instr_i = mk_instr(7'h1, 5'd9, 5'd8, 3'd2, 5'd12);
    rs2_data_i = 32'h5;
    tick("st_load");
    stall = 1; ctrl_i = 8'h00; imm_i = 32'h999; instr_i = 0;
    tick("st_e1");
    check("st_e1.rs2d_const", 64'(rs2_data_o), 64'h5);
    set_fwd(1, 1, 5'd9, 32'h77);
    tick("st_e2");
    check("st_e2.rs2d_const", 64'(rs2_data_o), 64'h77);
    set_fwd(1, 0, 5'd9, 32'h0);
    tick("st_e3");
    check("st_e3.rs2d_const", 64'(rs2_data_o), 64'h77);
    check("st_e3.ctrl_const", 64'(ctrl_o), 64'hC3);
    check("st_e3.imm_const", 64'(imm_o), 64'h444);
    check("st_e3.rd_const", 64'(rd_o), 64'd12);

    // clear beats stall
    clear = 1;
    tick("clr_stall");
    check("clr_stall.cnt_const", 64'(bubble_cnt_o), 64'd1);
    clear = 0; stall = 0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      clear      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      in_valid   = ($urandom_range(0, 4) != 0);
      ctrl_i     = 8'($urandom);
      instr_i    = $urandom;
      instr_i[19:15] = 5'($urandom_range(0, 7));
      instr_i[24:20] = 5'($urandom_range(0, 7));
      imm_i      = $urandom;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      for (int k = 0; k < 2; k++)
        set_fwd(k, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick("rand");
    end

    // asynchronous reset mid-cycle with registers loaded
    idle_inputs();
    instr_i = mk_instr(7'h7F, 5'd31, 5'd30, 3'd7, 5'd29);
    imm_i = 32'hCAFE; rs1_data_i = 32'h1; rs2_data_i = 32'h2;
    tick("pre_rst");
    #3;
    rst = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    rst = 1;

    // counter saturation on the 4-bit instance
    idle_inputs();
    in_valid = 0;
    for (int i = 0; i < 20; i++) tick("sat");
    check("sat.cnt4_const", 64'(s_cnt), 64'd15);
    check("sat.cnt16_const", 64'(bubble_cnt_o), 64'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
